// File: rtl/snn_config_loader_if.sv
// Byte-stream configuration channel: valid/ready data plus a synchronous frame abort.
// A byte transfers on the clock edge where cfg_valid and cfg_ready are both high.
interface snn_config_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_abort;

  modport master (output cfg_data, output cfg_valid, output cfg_abort, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input cfg_abort, output cfg_ready);
endinterface

// File: rtl/snn_config_loader.sv
// Framed, XOR-checksummed config loader: fills a shadow image byte by byte and commits it
// atomically to the active SNN parameter buses; network enable is gated until first commit.
module snn_config_loader #(
  parameter int          WEIGHT_BITS = 328,
  parameter int          DELAY_BITS  = 656,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  snn_config_loader_if.slave     cfg,
  input  logic                   run_en_i,
  output logic                   snn_enable_o,
  output logic                   cfg_loaded_o,
  output logic                   cfg_done_o,
  output logic                   cfg_error_o,
  output logic                   busy_o,
  output logic [4:0]             threshold_o,
  output logic [2:0]             decay_o,
  output logic [4:0]             refractory_period_o,
  output logic [WEIGHT_BITS-1:0] weights_o,
  output logic [DELAY_BITS-1:0]  delays_o,
  output logic [1:0]             state_o
);
  localparam int WB      = WEIGHT_BITS / 8;
  localparam int DB      = DELAY_BITS / 8;
  localparam int PAYLOAD = 2 + WB + DB;
  localparam int CW      = $clog2(PAYLOAD + 1);
  localparam int WIW     = $clog2(WEIGHT_BITS);
  localparam int DIW     = $clog2(DELAY_BITS);

  localparam logic [CW-1:0] PAYLOAD_C = CW'(PAYLOAD);
  localparam logic [CW-1:0] W_START_C = CW'(2);
  localparam logic [CW-1:0] D_START_C = CW'(2 + WB);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             xor_q, xor_d;
  logic [7:0]             chk_q, chk_d;
  logic [4:0]             sh_thr_q, sh_thr_d;
  logic [2:0]             sh_dec_q, sh_dec_d;
  logic [4:0]             sh_ref_q, sh_ref_d;
  logic [WEIGHT_BITS-1:0] sh_w_q, sh_w_d;
  logic [DELAY_BITS-1:0]  sh_d_q, sh_d_d;
  logic [4:0]             thr_q, thr_d;
  logic [2:0]             dec_q, dec_d;
  logic [4:0]             ref_q, ref_d;
  logic [WEIGHT_BITS-1:0] w_q, w_d;
  logic [DELAY_BITS-1:0]  d_q, d_d;
  logic                   loaded_q, loaded_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   ready;
  logic                   accept;
  logic [CW-1:0]          w_off, d_off;
  logic [WIW-1:0]         w_base;
  logic [DIW-1:0]         d_base;

  // Bit offsets of the current byte inside the weight / delay shadow buses.
  assign w_off  = cnt_q - W_START_C;
  assign d_off  = cnt_q - D_START_C;
  assign w_base = WIW'(w_off) << 3;
  assign d_base = DIW'(d_off) << 3;
  assign accept = cfg.cfg_valid & ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    chk_d    = chk_q;
    sh_thr_d = sh_thr_q;
    sh_dec_d = sh_dec_q;
    sh_ref_d = sh_ref_q;
    sh_w_d   = sh_w_q;
    sh_d_d   = sh_d_q;
    thr_d    = thr_q;
    dec_d    = dec_q;
    ref_d    = ref_q;
    w_d      = w_q;
    d_d      = d_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (accept && cfg.cfg_data == HEADER) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          xor_d   = '0;
        end
      end
      ST_LOAD: begin
        ready = 1'b1;
        // Abort wins over a byte presented in the same cycle.
        if (cfg.cfg_abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          if (cnt_q == PAYLOAD_C) begin
            chk_d   = cfg.cfg_data;
            state_d = ST_CHECK;
          end else begin
            xor_d = xor_q ^ cfg.cfg_data;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) begin
              sh_thr_d = cfg.cfg_data[4:0];
              sh_dec_d = cfg.cfg_data[7:5];
            end else if (cnt_q == CW'(1)) begin
              sh_ref_d = cfg.cfg_data[4:0];
            end else if (cnt_q < D_START_C) begin
              sh_w_d[w_base +: 8] = cfg.cfg_data;
            end else begin
              sh_d_d[d_base +: 8] = cfg.cfg_data;
            end
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (xor_q == chk_q) begin
          thr_d    = sh_thr_q;
          dec_d    = sh_dec_q;
          ref_d    = sh_ref_q;
          w_d      = sh_w_q;
          d_d      = sh_d_q;
          loaded_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      xor_q    <= '0;
      chk_q    <= '0;
      sh_thr_q <= '0;
      sh_dec_q <= '0;
      sh_ref_q <= '0;
      sh_w_q   <= '0;
      sh_d_q   <= '0;
      thr_q    <= '0;
      dec_q    <= '0;
      ref_q    <= '0;
      w_q      <= '0;
      d_q      <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      chk_q    <= chk_d;
      sh_thr_q <= sh_thr_d;
      sh_dec_q <= sh_dec_d;
      sh_ref_q <= sh_ref_d;
      sh_w_q   <= sh_w_d;
      sh_d_q   <= sh_d_d;
      thr_q    <= thr_d;
      dec_q    <= dec_d;
      ref_q    <= ref_d;
      w_q      <= w_d;
      d_q      <= d_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_ready         = ready;
  assign snn_enable_o          = run_en_i & loaded_q;
  assign cfg_loaded_o          = loaded_q;
  assign cfg_done_o            = done_q;
  assign cfg_error_o           = err_q;
  assign busy_o                = (state_q != ST_IDLE);
  assign threshold_o           = thr_q;
  assign decay_o               = dec_q;
  assign refractory_period_o   = ref_q;
  assign weights_o             = w_q;
  assign delays_o              = d_q;
  assign state_o               = state_q;
endmodule

// File: tb/tb_snn_config_loader.sv
// Bench for snn_config_loader: frames built from byte arrays, expected image derived from
// the frame layout and XOR checksum, compared at the commit edge and around it.
module tb_snn_config_loader;
  localparam int WBITS = 328;
  localparam int DBITS = 656;
  localparam int WB    = WBITS / 8;
  localparam int DB    = DBITS / 8;
  localparam int PAY   = 2 + WB + DB;

  logic             clk;
  logic             rst_n;
  logic             run_en;
  logic             snn_enable, cfg_loaded, cfg_done, cfg_error, busy;
  logic [4:0]       threshold, refractory;
  logic [2:0]       decay;
  logic [WBITS-1:0] weights;
  logic [DBITS-1:0] delays;
  logic [1:0]       state;

  snn_config_loader_if cfg_if ();

  snn_config_loader #(.WEIGHT_BITS(WBITS), .DELAY_BITS(DBITS), .HEADER(8'hA5)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg                 (cfg_if.slave),
    .run_en_i            (run_en),
    .snn_enable_o        (snn_enable),
    .cfg_loaded_o        (cfg_loaded),
    .cfg_done_o          (cfg_done),
    .cfg_error_o         (cfg_error),
    .busy_o              (busy),
    .threshold_o         (threshold),
    .decay_o             (decay),
    .refractory_period_o (refractory),
    .weights_o           (weights),
    .delays_o            (delays),
    .state_o             (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [7:0]       pay [PAY];
  logic [4:0]       f_thr, exp_thr;
  logic [2:0]       f_dec, exp_dec;
  logic [4:0]       f_ref, exp_ref;
  logic [WBITS-1:0] f_w, exp_w;
  logic [DBITS-1:0] f_d, exp_d;
  logic             exp_loaded;

  // Image the current payload describes, from the frame layout.
  task automatic model_image();
    f_thr = pay[0][4:0];
    f_dec = pay[0][7:5];
    f_ref = pay[1][4:0];
    for (int k = 0; k < WB; k++) f_w[8*k +: 8] = pay[2+k];
    for (int k = 0; k < DB; k++) f_d[8*k +: 8] = pay[2+WB+k];
  endtask

  task automatic model_commit();
    exp_thr = f_thr; exp_dec = f_dec; exp_ref = f_ref;
    exp_w = f_w; exp_d = f_d; exp_loaded = 1'b1;
  endtask

  task automatic model_reset();
    exp_thr = '0; exp_dec = '0; exp_ref = '0;
    exp_w = '0; exp_d = '0; exp_loaded = 1'b0;
  endtask

  task automatic fill_pattern(input logic [4:0] thr, input logic [2:0] dec, input logic [4:0] rp);
    pay[0] = {dec, thr};
    pay[1] = {3'b000, rp};
    for (int k = 0; k < WB; k++) pay[2+k]    = 8'(k);
    for (int k = 0; k < DB; k++) pay[2+WB+k] = 8'h80 | 8'(k);
    model_image();
  endtask

  task automatic fill_random();
    for (int k = 0; k < PAY; k++) pay[k] = 8'($urandom_range(0, 255));
    model_image();
  endtask

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    for (int k = 0; k < PAY; k++) x = x ^ pay[k];
    return x;
  endfunction

  // ---------------- drivers ----------------
  // Presents one byte; returns at 1 time unit after the edge that transferred it.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    int waited = 0;
    for (int g = 0; g < gaps; g++) begin
      cfg_if.cfg_valid = 1'b0;
      @(posedge clk); #1;
    end
    cfg_if.cfg_data  = b;
    cfg_if.cfg_valid = 1'b1;
    while (!cfg_if.cfg_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cfg_if.cfg_ready) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: cfg_ready=%b, required 1 within 50 cycles", cfg_if.cfg_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int gap_max, input logic [7:0] chk_flip);
    send_byte(8'hA5, gap_max);
    for (int k = 0; k < PAY; k++) send_byte(pay[k], gap_max);
    send_byte(frame_xor() ^ chk_flip, gap_max);
    cfg_if.cfg_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; run_en = 1'b1;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_abort = 1'b0; cfg_if.cfg_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (snn_enable !== 1'b0 || weights !== exp_w || cfg_if.cfg_ready !== 1'b1 || cfg_loaded !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: en=%b w0=%h rdy=%b ld=%b busy=%b, required 0 0 1 0 0",
               snn_enable, weights[31:0], cfg_if.cfg_ready, cfg_loaded, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    fill_pattern(5'd9, 3'd2, 5'd4);
    send_frame(0, 8'h00);
    n_tests++;
    if (cfg_done !== 1'b0 || cfg_if.cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL good_check_state: done=%b rdy=%b busy=%b, required 0 0 1", cfg_done, cfg_if.cfg_ready, busy);
    end
    model_commit();
    @(posedge clk); #1;
    n_tests++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || cfg_loaded !== 1'b1 || snn_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL good_flags: done=%b err=%b ld=%b en=%b, required 1 0 1 1", cfg_done, cfg_error, cfg_loaded, snn_enable);
    end
    n_tests++;
    if (threshold !== exp_thr || decay !== exp_dec || refractory !== exp_ref || weights !== exp_w || delays !== exp_d) begin
      n_fail++;
      $display("FAIL good_image: thr=%h/%h dec=%h/%h ref=%h/%h w0=%h/%h d0=%h/%h (actual/required)",
               threshold, exp_thr, decay, exp_dec, refractory, exp_ref, weights[31:0], exp_w[31:0], delays[31:0], exp_d[31:0]);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cfg_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL good_pulse_end: done=%b busy=%b, required 0 0", cfg_done, busy);
    end
  endtask

  task automatic test_bad_checksum();
    fill_pattern(5'd9, 3'd2, 5'd4);
    send_frame(0, 8'h01);
    @(posedge clk); #1;
    n_tests++;
    if (cfg_error !== 1'b1 || cfg_done !== 1'b0 || cfg_loaded !== exp_loaded) begin
      n_fail++;
      $display("FAIL bad_flags: err=%b done=%b ld=%b, required 1 0 %b", cfg_error, cfg_done, cfg_loaded, exp_loaded);
    end
    n_tests++;
    if (threshold !== exp_thr || weights !== exp_w || delays !== exp_d) begin
      n_fail++;
      $display("FAIL bad_image_kept: thr=%h/%h w0=%h/%h (actual/required)", threshold, exp_thr, weights[31:0], exp_w[31:0]);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cfg_error !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_pulse_end: err=%b, required 0", cfg_error);
    end
  endtask

  task automatic test_abort();
    int done_seen = 0;
    fill_random();
    send_byte(8'hA5, 0);
    for (int k = 0; k < 60; k++) send_byte(pay[k], 0);
    cfg_if.cfg_abort = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    cfg_if.cfg_abort = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || cfg_done !== 1'b0 || cfg_error !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b err=%b, required 0 0 0", busy, cfg_done, cfg_error);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (cfg_done === 1'b1) done_seen++;
    end
    n_tests++;
    if (done_seen != 0 || weights !== exp_w || cfg_loaded !== exp_loaded) begin
      n_fail++;
      $display("FAIL abort_no_commit: done_seen=%0d w0=%h/%h, required 0 and old image", done_seen, weights[31:0], exp_w[31:0]);
    end
    fill_random();
    send_frame(0, 8'h00);
    model_commit();
    @(posedge clk); #1;
    n_tests++;
    if (cfg_done !== 1'b1 || threshold !== exp_thr || decay !== exp_dec || refractory !== exp_ref || weights !== exp_w || delays !== exp_d) begin
      n_fail++;
      $display("FAIL abort_then_b: done=%b thr=%h/%h w0=%h/%h d0=%h/%h (actual/required)",
               cfg_done, threshold, exp_thr, weights[31:0], exp_w[31:0], delays[31:0], exp_d[31:0]);
    end
  endtask

  task automatic test_idle_noise_gaps();
    logic [7:0] noise [2];
    noise[0] = 8'h00; noise[1] = 8'h5A;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      send_byte(noise[i], 0);
      n_tests++;
      if (busy !== 1'b0 || cfg_error !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_noise_%0d: busy=%b err=%b, required 0 0", i, busy, cfg_error);
      end
    end
    cfg_if.cfg_valid = 1'b0;
    fill_random();
    send_frame(3, 8'h00);
    model_commit();
    @(posedge clk); #1;
    n_tests++;
    if (cfg_done !== 1'b1 || threshold !== exp_thr || decay !== exp_dec || refractory !== exp_ref || weights !== exp_w || delays !== exp_d) begin
      n_fail++;
      $display("FAIL gapped_frame: done=%b thr=%h/%h ref=%h/%h w0=%h/%h d0=%h/%h (actual/required)",
               cfg_done, threshold, exp_thr, refractory, exp_ref, weights[31:0], exp_w[31:0], delays[31:0], exp_d[31:0]);
    end
  endtask

  // Per-cycle watch of the live weights while a reload streams in.
  logic             mon_en = 1'b0;
  logic [WBITS-1:0] mon_w;
  int               mon_bad = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (weights !== mon_w) begin
        n_fail++;
        mon_bad++;
        if (mon_bad < 5)
          $display("FAIL live_weights: w0=%h, required %h", weights[31:0], mon_w[31:0]);
      end
    end
  end

  task automatic test_reload_live();
    mon_w  = exp_w;
    mon_en = 1'b1;
    fill_random();
    send_frame(1, 8'h00);
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL check_not_ready: rdy=%b, required 0", cfg_if.cfg_ready);
    end
    model_commit();
    @(posedge clk); #1;
    mon_w = exp_w;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_tests++;
    if (delays !== exp_d || threshold !== exp_thr || snn_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_result: d0=%h/%h thr=%h/%h en=%b", delays[31:0], exp_d[31:0], threshold, exp_thr, snn_enable);
    end
  endtask

  task automatic test_reset_midframe();
    fill_random();
    send_byte(8'hA5, 0);
    for (int k = 0; k < 30; k++) send_byte(pay[k], 0);
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (weights !== exp_w || delays !== exp_d || threshold !== exp_thr || decay !== exp_dec ||
        refractory !== exp_ref || cfg_loaded !== 1'b0 || snn_enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: w0=%h d0=%h thr=%h ld=%b en=%b busy=%b, required all 0",
               weights[31:0], delays[31:0], threshold, cfg_loaded, snn_enable, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random();
    send_frame(0, 8'h00);
    model_commit();
    @(posedge clk); #1;
    n_tests++;
    if (cfg_done !== 1'b1 || cfg_loaded !== 1'b1 || weights !== exp_w || delays !== exp_d || decay !== exp_dec) begin
      n_fail++;
      $display("FAIL after_reset_load: done=%b ld=%b w0=%h/%h d0=%h/%h", cfg_done, cfg_loaded,
               weights[31:0], exp_w[31:0], delays[31:0], exp_d[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_abort();
    test_idle_noise_gaps();
    test_reload_live();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
